// File: rtl/weight_bias_dispatch.sv
// -----------------------------------------------------------------------------
// weight_bias_dispatch
//
// Purpose:
//   Consumes the bias/weight read stream coming out of the AXI reader and
//   steers each beat to its destination. Bias beats come first and are
//   written sequentially into the bias buffer. Weight beats follow and are
//   spread round-robin across C_BANKS PE weight banks; all banks share one
//   write address, which advances each time the bank index wraps. When all
//   expected beats have been written, O_load_done is raised and held for the
//   layer controller.
//
// Optional feature (compile-time macro WB_PHASE_CHECK_EN):
//   defined   : O_err_phase flags beats whose I_weight_ch disagrees with the
//               current FSM phase. Routing still follows the FSM.
//   undefined : O_err_phase is tied 0 and I_weight_ch is ignored.
//
// Ports:
//   I_clk            clock
//   I_rst            synchronous reset, active high
//   I_ap_start       layer start level; a rising edge (re)starts a load
//   I_bias_beats     number of bias beats expected
//   I_weight_beats   number of weight beats expected
//   I_mem_din        stream beat from the reader
//   I_mem_din_valid  beat valid (no backpressure)
//   I_weight_ch      reader phase flag: 0 bias, 1 weight
//   O_bias_we        bias buffer write enable (single-cycle pulse)
//   O_bias_waddr     bias buffer write address
//   O_bias_wdata     bias buffer write data
//   O_wt_we          one-hot weight bank write enable (single-cycle pulse)
//   O_wt_waddr       weight write address, common to all banks
//   O_wt_wdata       weight write data
//   O_load_done      level: every expected beat has been written
//   O_err_overrun    sticky: a beat arrived while IDLE or DONE
//   O_err_phase      sticky: phase flag mismatch (only with WB_PHASE_CHECK_EN)
// -----------------------------------------------------------------------------
module weight_bias_dispatch #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_BANKS      = 4,
  parameter int C_BIAS_AW    = 8,
  parameter int C_WT_AW      = 10
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    I_ap_start,
  input  logic [15:0]             I_bias_beats,
  input  logic [31:0]             I_weight_beats,
  input  logic [C_DATA_WIDTH-1:0] I_mem_din,
  input  logic                    I_mem_din_valid,
  input  logic                    I_weight_ch,
  output logic                    O_bias_we,
  output logic [C_BIAS_AW-1:0]    O_bias_waddr,
  output logic [C_DATA_WIDTH-1:0] O_bias_wdata,
  output logic [C_BANKS-1:0]      O_wt_we,
  output logic [C_WT_AW-1:0]      O_wt_waddr,
  output logic [C_DATA_WIDTH-1:0] O_wt_wdata,
  output logic                    O_load_done,
  output logic                    O_err_overrun,
  output logic                    O_err_phase
);

  localparam int C_BANK_AW = (C_BANKS > 1) ? $clog2(C_BANKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BIAS   = 2'd1,
    S_WEIGHT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    ap_start_q;
  logic [15:0]             bias_beats_q;
  logic [31:0]             wt_beats_q;
  logic [15:0]             bias_cnt_q;
  logic [31:0]             wt_cnt_q;
  logic [C_BANK_AW-1:0]    bank_idx_q;
  logic [C_WT_AW-1:0]      wt_addr_q;

  logic                    bias_we_q;
  logic [C_BIAS_AW-1:0]    bias_waddr_q;
  logic [C_DATA_WIDTH-1:0] bias_wdata_q;
  logic [C_BANKS-1:0]      wt_we_q;
  logic [C_WT_AW-1:0]      wt_waddr_q;
  logic [C_DATA_WIDTH-1:0] wt_wdata_q;
  logic                    load_done_q;
  logic                    err_overrun_q;

  // Combinational next values / decodes used by the FSM.
  logic                    start_edge;
  logic [15:0]             bias_cnt_d;
  logic [31:0]             wt_cnt_d;
  logic [C_BANK_AW-1:0]    bank_idx_d;
  logic                    bias_last;
  logic                    wt_last;
  logic                    bank_wrap;
  logic [C_BANKS-1:0]      bank_onehot;

  assign start_edge = I_ap_start & ~ap_start_q;
  assign bias_cnt_d = bias_cnt_q + 16'd1;
  assign wt_cnt_d   = wt_cnt_q + 32'd1;
  assign bank_idx_d = bank_idx_q + C_BANK_AW'(1);
  assign bias_last  = (bias_cnt_q == bias_beats_q - 16'd1);
  assign wt_last    = (wt_cnt_q == wt_beats_q - 32'd1);
  // The shared weight address advances after the last bank has been written.
  assign bank_wrap  = (bank_idx_q == C_BANK_AW'(C_BANKS - 1));

  for (genvar gi = 0; gi < C_BANKS; gi++) begin : g_bank_sel
    assign bank_onehot[gi] = (bank_idx_q == C_BANK_AW'(gi));
  end

`ifdef WB_PHASE_CHECK_EN
  logic err_phase_q;
  assign O_err_phase = err_phase_q;
`else
  logic unused_weight_ch;
  assign unused_weight_ch = I_weight_ch;
  assign O_err_phase      = 1'b0;
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q       <= S_IDLE;
      ap_start_q    <= 1'b0;
      bias_beats_q  <= '0;
      wt_beats_q    <= '0;
      bias_cnt_q    <= '0;
      wt_cnt_q      <= '0;
      bank_idx_q    <= '0;
      wt_addr_q     <= '0;
      bias_we_q     <= 1'b0;
      bias_waddr_q  <= '0;
      bias_wdata_q  <= '0;
      wt_we_q       <= '0;
      wt_waddr_q    <= '0;
      wt_wdata_q    <= '0;
      load_done_q   <= 1'b0;
      err_overrun_q <= 1'b0;
`ifdef WB_PHASE_CHECK_EN
      err_phase_q   <= 1'b0;
`endif
    end else begin
      ap_start_q <= I_ap_start;
      // Write strobes are pulses; address/data keep their last value.
      bias_we_q  <= 1'b0;
      wt_we_q    <= '0;

      if (start_edge) begin
        // A start edge restarts from any state; a coincident beat is dropped.
        bias_beats_q  <= I_bias_beats;
        wt_beats_q    <= I_weight_beats;
        bias_cnt_q    <= '0;
        wt_cnt_q      <= '0;
        bank_idx_q    <= '0;
        wt_addr_q     <= '0;
        load_done_q   <= 1'b0;
        err_overrun_q <= 1'b0;
`ifdef WB_PHASE_CHECK_EN
        err_phase_q   <= 1'b0;
`endif
        if (I_bias_beats != 16'd0) begin
          state_q <= S_BIAS;
        end else if (I_weight_beats != 32'd0) begin
          state_q <= S_WEIGHT;
        end else begin
          state_q <= S_DONE;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (I_mem_din_valid) begin
              err_overrun_q <= 1'b1;
            end
          end

          S_BIAS: begin
            if (I_mem_din_valid) begin
              bias_we_q    <= 1'b1;
              bias_waddr_q <= bias_cnt_q[C_BIAS_AW-1:0];
              bias_wdata_q <= I_mem_din;
              bias_cnt_q   <= bias_cnt_d;
`ifdef WB_PHASE_CHECK_EN
              if (I_weight_ch) begin
                err_phase_q <= 1'b1;
              end
`endif
              if (bias_last) begin
                state_q <= (wt_beats_q != 32'd0) ? S_WEIGHT : S_DONE;
              end
            end
          end

          S_WEIGHT: begin
            if (I_mem_din_valid) begin
              wt_we_q    <= bank_onehot;
              wt_waddr_q <= wt_addr_q;
              wt_wdata_q <= I_mem_din;
              bank_idx_q <= bank_idx_d;
              wt_cnt_q   <= wt_cnt_d;
              if (bank_wrap) begin
                wt_addr_q <= wt_addr_q + C_WT_AW'(1);
              end
`ifdef WB_PHASE_CHECK_EN
              if (!I_weight_ch) begin
                err_phase_q <= 1'b1;
              end
`endif
              if (wt_last) begin
                state_q <= S_DONE;
              end
            end
          end

          S_DONE: begin
            // Done rises the cycle after the final write and holds.
            load_done_q <= 1'b1;
            if (I_mem_din_valid) begin
              err_overrun_q <= 1'b1;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign O_bias_we     = bias_we_q;
  assign O_bias_waddr  = bias_waddr_q;
  assign O_bias_wdata  = bias_wdata_q;
  assign O_wt_we       = wt_we_q;
  assign O_wt_waddr    = wt_waddr_q;
  assign O_wt_wdata    = wt_wdata_q;
  assign O_load_done   = load_done_q;
  assign O_err_overrun = err_overrun_q;

endmodule

// File: tb/tb_weight_bias_dispatch.sv
// Self-checking bench for weight_bias_dispatch. Expected writes are pushed to
// scoreboard queues as beats are driven and popped by a monitor on the falling
// edge, which also checks that each write lands exactly one cycle after its beat.
module tb_weight_bias_dispatch;

  localparam int DW  = 128;
  localparam int NB  = 4;
  localparam int BAW = 8;
  localparam int WAW = 10;

`ifdef WB_PHASE_CHECK_EN
  localparam logic PH_EN = 1'b1;
`else
  localparam logic PH_EN = 1'b0;
`endif

  logic            I_clk = 1'b0;
  logic            I_rst = 1'b1;
  logic            I_ap_start = 1'b0;
  logic [15:0]     I_bias_beats = '0;
  logic [31:0]     I_weight_beats = '0;
  logic [DW-1:0]   I_mem_din = '0;
  logic            I_mem_din_valid = 1'b0;
  logic            I_weight_ch = 1'b0;
  logic            O_bias_we;
  logic [BAW-1:0]  O_bias_waddr;
  logic [DW-1:0]   O_bias_wdata;
  logic [NB-1:0]   O_wt_we;
  logic [WAW-1:0]  O_wt_waddr;
  logic [DW-1:0]   O_wt_wdata;
  logic            O_load_done;
  logic            O_err_overrun;
  logic            O_err_phase;

  weight_bias_dispatch #(
    .C_DATA_WIDTH(DW), .C_BANKS(NB), .C_BIAS_AW(BAW), .C_WT_AW(WAW)
  ) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_ap_start(I_ap_start),
    .I_bias_beats(I_bias_beats), .I_weight_beats(I_weight_beats),
    .I_mem_din(I_mem_din), .I_mem_din_valid(I_mem_din_valid),
    .I_weight_ch(I_weight_ch),
    .O_bias_we(O_bias_we), .O_bias_waddr(O_bias_waddr), .O_bias_wdata(O_bias_wdata),
    .O_wt_we(O_wt_we), .O_wt_waddr(O_wt_waddr), .O_wt_wdata(O_wt_wdata),
    .O_load_done(O_load_done), .O_err_overrun(O_err_overrun), .O_err_phase(O_err_phase)
  );

  always #5 I_clk = ~I_clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge I_clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [BAW-1:0] addr; logic [DW-1:0] data; } bias_exp_t;
  typedef struct { int cyc; logic [NB-1:0] we; logic [WAW-1:0] addr; logic [DW-1:0] data; } wt_exp_t;

  bias_exp_t bias_sb[$];
  wt_exp_t   wt_sb[$];

  // Reference model of the load in progress.
  int m_bias_n = 0, m_wt_n = 0, m_bias_i = 0, m_wt_i = 0;

  always @(negedge I_clk) begin : monitor
    bias_exp_t be;
    wt_exp_t   we_e;
    if (O_bias_we === 1'b1) begin
      compared++;
      if (bias_sb.size() == 0) begin
        mismatched++;
        $display("FAIL bias_unexpected: got write addr=%0d data=%h, required no write", O_bias_waddr, O_bias_wdata);
      end else begin
        be = bias_sb.pop_front();
        if (O_bias_waddr !== be.addr || O_bias_wdata !== be.data || cyc !== be.cyc) begin
          mismatched++;
          $display("FAIL bias_write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   O_bias_waddr, O_bias_wdata, cyc, be.addr, be.data, be.cyc);
        end
      end
    end
    if (O_wt_we !== '0 && !$isunknown(O_wt_we)) begin
      compared++;
      if (wt_sb.size() == 0) begin
        mismatched++;
        $display("FAIL wt_unexpected: got we=%b addr=%0d data=%h, required no write", O_wt_we, O_wt_waddr, O_wt_wdata);
      end else begin
        we_e = wt_sb.pop_front();
        if (O_wt_we !== we_e.we || O_wt_waddr !== we_e.addr || O_wt_wdata !== we_e.data || cyc !== we_e.cyc) begin
          mismatched++;
          $display("FAIL wt_write: got we=%b addr=%0d data=%h cyc=%0d, required we=%b addr=%0d data=%h cyc=%0d",
                   O_wt_we, O_wt_waddr, O_wt_wdata, cyc, we_e.we, we_e.addr, we_e.data, we_e.cyc);
        end
      end
    end
  end

  function automatic logic [DW-1:0] mk(input int k);
    logic [31:0] w;
    w = 32'hD0A0_0000 + 32'(k);
    return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'h1111_0000};
  endfunction

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic start_load(input int nb, input int nw);
    I_ap_start      = 1'b0;
    I_mem_din_valid = 1'b0;
    step();
    I_bias_beats    = 16'(nb);
    I_weight_beats  = 32'(nw);
    I_ap_start      = 1'b1;
    step();
    m_bias_n = nb; m_wt_n = nw; m_bias_i = 0; m_wt_i = 0;
  endtask

  // Drive one beat for one cycle and record what the DUT should write for it.
  task automatic send_beat(input logic [DW-1:0] d, input logic ch);
    bias_exp_t be;
    wt_exp_t   we_e;
    if (m_bias_i < m_bias_n) begin
      be.cyc = cyc + 1; be.addr = m_bias_i[BAW-1:0]; be.data = d;
      bias_sb.push_back(be);
      m_bias_i++;
    end else if (m_wt_i < m_wt_n) begin
      we_e.cyc  = cyc + 1;
      we_e.we   = NB'(1 << (m_wt_i % NB));
      we_e.addr = WAW'((m_wt_i / NB) % (1 << WAW));
      we_e.data = d;
      wt_sb.push_back(we_e);
      m_wt_i++;
    end
    I_mem_din       = d;
    I_weight_ch     = ch;
    I_mem_din_valid = 1'b1;
    step();
    I_mem_din_valid = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  task automatic check_drained(input string name);
    step();
    compared++;
    if (bias_sb.size() != 0 || wt_sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drained: pending bias=%0d wt=%0d, required 0/0", name, bias_sb.size(), wt_sb.size());
      bias_sb.delete();
      wt_sb.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    compared++;
    if (O_bias_we !== 1'b0 || O_bias_waddr !== '0 || O_bias_wdata !== '0 ||
        O_wt_we !== '0 || O_wt_waddr !== '0 || O_wt_wdata !== '0 ||
        O_load_done !== 1'b0 || O_err_overrun !== 1'b0 || O_err_phase !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: got bwe=%b baddr=%0d bdata=%h wwe=%b waddr=%0d wdata=%h done=%b ovr=%b ph=%b, required all 0",
               name, O_bias_we, O_bias_waddr, O_bias_wdata, O_wt_we, O_wt_waddr, O_wt_wdata,
               O_load_done, O_err_overrun, O_err_phase);
    end
  endtask

  task automatic test_reset();
    I_rst = 1'b1;
    step(); step(); step();
    check_outputs_zero("reset_outputs");
    I_rst = 1'b0;
    step();
    // A beat in IDLE is discarded and flagged.
    m_bias_n = 0; m_wt_n = 0; m_bias_i = 0; m_wt_i = 0;
    send_beat(mk(500), 1'b0);
    check_bit("idle_overrun", O_err_overrun, 1'b1);
    check_drained("idle");
  endtask

  task automatic test_continuous();
    start_load(2, 8);
    for (int k = 0; k < 10; k++) send_beat(mk(k), (k >= 2));
    check_bit("t1_done_with_last_write", O_load_done, 1'b0);
    step();
    check_bit("t1_done", O_load_done, 1'b1);
    check_bit("t1_overrun", O_err_overrun, 1'b0);
    check_bit("t1_phase", O_err_phase, 1'b0);
    check_drained("t1");
  endtask

  task automatic test_overrun();
    send_beat(mk(99), 1'b1);
    check_bit("t4_overrun_set", O_err_overrun, 1'b1);
    check_bit("t4_done_held", O_load_done, 1'b1);
    check_drained("t4");
    start_load(1, 1);
    check_bit("t4_overrun_cleared", O_err_overrun, 1'b0);
    check_bit("t4_done_cleared", O_load_done, 1'b0);
    send_beat(mk(40), 1'b0);
    send_beat(mk(41), 1'b1);
    step();
    check_bit("t4_reload_done", O_load_done, 1'b1);
    check_drained("t4_reload");
  endtask

  task automatic test_bias_zero();
    start_load(0, 3);
    for (int k = 0; k < 3; k++) send_beat(mk(100 + k), 1'b1);
    step();
    check_bit("t2_done", O_load_done, 1'b1);
    check_drained("t2");
  endtask

  task automatic test_toggle();
    start_load(4, 5);
    for (int k = 0; k < 9; k++) begin
      send_beat(mk(200 + k), (k >= 4));
      if (k != 8) step();
    end
    check_bit("t3_done_with_last_write", O_load_done, 1'b0);
    step();
    check_bit("t3_done", O_load_done, 1'b1);
    check_drained("t3");
  endtask

  task automatic test_reset_mid();
    start_load(0, 8);
    for (int k = 0; k < 3; k++) send_beat(mk(300 + k), 1'b1);
    I_ap_start = 1'b0;
    I_rst = 1'b1;
    step();
    check_outputs_zero("t5_reset_outputs");
    step();
    I_rst = 1'b0;
    start_load(1, 1);
    send_beat(mk(310), 1'b0);
    send_beat(mk(311), 1'b1);
    step();
    check_bit("t5_done", O_load_done, 1'b1);
    check_drained("t5");
  endtask

  task automatic test_empty();
    bit seen;
    start_load(0, 0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (O_load_done === 1'b1) seen = 1'b1;
      else step();
    end
    check_bit("empty_done_within_bound", seen, 1'b1);
  endtask

  task automatic test_phase();
    start_load(1, 1);
    send_beat(mk(400), 1'b1);
    check_bit("t6_phase_flag", O_err_phase, PH_EN);
    send_beat(mk(401), 1'b1);
    step();
    check_bit("t6_done", O_load_done, 1'b1);
    check_drained("t6");
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_overrun();
    test_bias_zero();
    test_toggle();
    test_reset_mid();
    test_empty();
    test_phase();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
